// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and constants for the PPU OAM DMA block.
//   dma_state_e      - DMA engine FSM states
//   OAM_BYTES        - bytes copied per transfer (one full OAM)
//   DMA_START_DELAY  - clocks between the register write and the first byte
//   REG_DMA_ADDR     - low address bits of the DMA register (0xFF46)
//   dma_page_eff()   - folds echo-RAM source pages onto work RAM
package ppu_pkg;

  typedef enum logic [1:0] {
    DmaIdle     = 2'd0,
    DmaStart    = 2'd1,
    DmaTransfer = 2'd2
  } dma_state_e;

  localparam int         OAM_BYTES       = 160;
  localparam int         DMA_START_DELAY = 4;
  localparam logic [6:0] REG_DMA_ADDR    = 7'h46;

  // Pages 0xE0..0xFF are the echo of 0xC0..0xDF; the DMA reads the
  // underlying RAM rather than the mirror.
  function automatic logic [7:0] dma_page_eff(input logic [7:0] page);
    return (page >= 8'hE0) ? page - 8'h20 : page;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// oam_dma: OAM DMA controller and OAM port arbiter.
//   A write to the DMA register latches a source page and, after
//   START_DELAY clocks, copies OAM_BYTES bytes from {page, 8'h00} into
//   OAM at one byte per 4-clock M-cycle. The block owns the PPU OAM port
//   and muxes it between the CPU and the DMA engine.
// Ports:
//   clk, reset_n                      - clock, async active-low reset
//   reg_enable/reg_write/reg_data_in  - DMA register access
//   reg_data_out                      - registered readback of last write
//   dma_bus_addr/dma_bus_read         - system bus read request
//   dma_bus_data_in                   - bus data, one clock after the read
//   cpu_oam_*                         - CPU OAM request / read data
//   oam_addr/enable/write/data_out    - PPU OAM port (driven)
//   oam_data_in                       - PPU OAM read data (1-cycle latency)
//   dma_active                        - transfer in progress, CPU bus blocked
module oam_dma #(
  parameter int OAM_BYTES   = ppu_pkg::OAM_BYTES,
  parameter int START_DELAY = ppu_pkg::DMA_START_DELAY
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reg_enable,
  input  logic        reg_write,
  input  logic [7:0]  reg_data_in,
  output logic [7:0]  reg_data_out,
  output logic [15:0] dma_bus_addr,
  output logic        dma_bus_read,
  input  logic [7:0]  dma_bus_data_in,
  input  logic [7:0]  cpu_oam_addr,
  input  logic        cpu_oam_enable,
  input  logic        cpu_oam_write,
  input  logic [7:0]  cpu_oam_data_in,
  output logic [7:0]  cpu_oam_data_out,
  output logic [7:0]  oam_addr,
  output logic        oam_enable,
  output logic        oam_write,
  output logic [7:0]  oam_data_out,
  input  logic [7:0]  oam_data_in,
  output logic        dma_active
);
  import ppu_pkg::*;

  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  dma_state_e    state_q, state_d;
  logic [7:0]    source_q;
  logic [7:0]    idx_q;
  logic [1:0]    phase_q;
  logic [DW-1:0] dly_q;
  logic          restart_q;  // current Start was entered from a live transfer
  logic          blocked_q;

  logic reg_wr;
  logic last_byte;
  logic in_xfer;

  assign reg_wr    = reg_enable & reg_write;
  assign in_xfer   = (state_q == DmaTransfer);
  assign last_byte = (phase_q == 2'd3) && (idx_q == 8'(OAM_BYTES - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= DmaIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    dma_bus_addr = 16'h0000;
    dma_bus_read = 1'b0;
    // CPU owns the OAM port unless a transfer is running.
    oam_addr     = cpu_oam_addr;
    oam_enable   = cpu_oam_enable;
    oam_write    = cpu_oam_write;
    oam_data_out = cpu_oam_data_in;

    unique case (state_q)
      DmaIdle: ;
      DmaStart:
        if (dly_q == DW'(START_DELAY - 1)) state_d = DmaTransfer;
      DmaTransfer:
        if (last_byte) state_d = DmaIdle;
      default: state_d = DmaIdle;
    endcase
    // A register write restarts from any state, including the final byte.
    if (reg_wr) state_d = DmaStart;

    if (in_xfer) begin
      oam_addr     = 8'h00;
      oam_enable   = 1'b0;
      oam_write    = 1'b0;
      oam_data_out = 8'h00;
      dma_bus_addr = {dma_page_eff(source_q), idx_q};
      dma_bus_read = (phase_q == 2'd0);
      // Bus data from the phase-0 read arrives here and goes straight to OAM.
      if (phase_q == 2'd1) begin
        oam_addr     = idx_q;
        oam_enable   = 1'b1;
        oam_write    = 1'b1;
        oam_data_out = dma_bus_data_in;
      end
    end
  end

  // ----------------------------------------------------------- counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      source_q  <= 8'h00;
      idx_q     <= 8'h00;
      phase_q   <= 2'd0;
      dly_q     <= '0;
      restart_q <= 1'b0;
    end else if (reg_wr) begin
      source_q  <= reg_data_in;
      idx_q     <= 8'h00;
      phase_q   <= 2'd0;
      dly_q     <= '0;
      // Keep dma_active up across the restart delay if bytes were moving.
      restart_q <= in_xfer || ((state_q == DmaStart) && restart_q);
    end else begin
      unique case (state_q)
        DmaStart: dly_q <= dly_q + 1'b1;
        DmaTransfer: begin
          phase_q <= phase_q + 2'd1;
          if (phase_q == 2'd3) idx_q <= idx_q + 8'd1;
        end
        default: ;
      endcase
      if (state_d != DmaStart) restart_q <= 1'b0;
    end
  end

  // ------------------------------------------------- register / CPU read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_data_out <= 8'h00;
      blocked_q    <= 1'b0;
    end else begin
      if (reg_enable && !reg_write) reg_data_out <= source_q;
      blocked_q <= in_xfer && cpu_oam_enable && !cpu_oam_write;
    end
  end

  assign cpu_oam_data_out = blocked_q ? 8'hFF : oam_data_in;
  assign dma_active       = in_xfer || ((state_q == DmaStart) && restart_q);

endmodule
